// File: rtl/ped_walk_controller_if.sv
// Signal bundle between the upstream light controller / push-button and the pedestrian head.
// The master side drives lights and button; the controller sits on the slave side.
interface ped_walk_controller_if;
    logic       red;
    logic       yellow;
    logic       green;
    logic       ped_button;
    logic       walk;
    logic       dont_walk;
    logic       flash;
    logic [3:0] countdown;
    logic       req_pending;
    logic       fault;

    modport master (
        output red, yellow, green, ped_button,
        input  walk, dont_walk, flash, countdown, req_pending, fault
    );

    modport slave (
        input  red, yellow, green, ped_button,
        output walk, dont_walk, flash, countdown, req_pending, fault
    );
endinterface

// File: rtl/ped_walk_controller.sv
// Pedestrian walk / don't-walk head driven from the traffic light state and a debounced push-button.
// Walk is granted only on a red rising edge with a latched request; illegal light codes lock into FAULT.
module ped_walk_controller #(
    parameter int DEBOUNCE     = 4,
    parameter int WALK_CYCLES  = 8,
    parameter int CLEAR_CYCLES = 6,
    parameter int BLINK_HALF   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    ped_walk_controller_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int PH_W = $clog2(WALK_CYCLES + 1);
    localparam int BL_W = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_CLEAR,
        S_FAULT
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_deb_d;
    logic            r_red_d;
    logic [PH_W-1:0] r_walk_cnt;
    logic [BL_W-1:0] r_blink_cnt;
    logic            r_walk;
    logic            r_dont_walk;
    logic            r_flash;
    logic [3:0]      r_countdown;
    logic            r_req;
    logic            r_fault;

    logic            w_deb;
    logic            w_press;
    logic            w_red_rise;
    logic            w_legal;

    // Counter saturates at DEBOUNCE, so a held button yields a single rising edge.
    assign w_deb      = (r_db_cnt == DB_W'(DEBOUNCE));
    assign w_press    = w_deb & ~r_deb_d;
    assign w_red_rise = bus.red & ~r_red_d;
    assign w_legal    = $onehot({bus.red, bus.yellow, bus.green});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db_cnt <= '0;
            r_deb_d  <= 1'b0;
            r_red_d  <= 1'b0;
        end else begin
            r_sync1 <= bus.ped_button;
            r_sync2 <= r_sync1;
            r_deb_d <= w_deb;
            r_red_d <= bus.red;
            if (!r_sync2) begin
                r_db_cnt <= '0;
            end else if (!w_deb) begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_walk_cnt  <= '0;
            r_blink_cnt <= '0;
            r_walk      <= 1'b0;
            r_dont_walk <= 1'b1;
            r_flash     <= 1'b0;
            r_countdown <= 4'd0;
            r_req       <= 1'b0;
            r_fault     <= 1'b0;
        end else if (!w_legal || r_state == S_FAULT) begin
            r_state     <= S_FAULT;
            r_walk      <= 1'b0;
            r_dont_walk <= 1'b1;
            r_flash     <= 1'b0;
            r_countdown <= 4'd0;
            r_req       <= 1'b0;
            r_fault     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_red_rise && r_req) begin
                        r_state     <= S_WALK;
                        r_walk_cnt  <= '0;
                        r_walk      <= 1'b1;
                        r_dont_walk <= 1'b0;
                        r_req       <= 1'b0;
                    end
                end
                S_WALK: begin
                    if (!bus.red) begin
                        r_state     <= S_IDLE;
                        r_walk      <= 1'b0;
                        r_dont_walk <= 1'b1;
                    end else if (r_walk_cnt == PH_W'(WALK_CYCLES - 1)) begin
                        r_state     <= S_CLEAR;
                        r_walk      <= 1'b0;
                        r_dont_walk <= 1'b1;
                        r_flash     <= 1'b1;
                        r_countdown <= 4'(CLEAR_CYCLES - 1);
                        r_blink_cnt <= '0;
                    end else begin
                        r_walk_cnt <= r_walk_cnt + PH_W'(1);
                    end
                end
                S_CLEAR: begin
                    if (!bus.red || r_countdown == 4'd0) begin
                        r_state     <= S_IDLE;
                        r_dont_walk <= 1'b1;
                        r_flash     <= 1'b0;
                        r_countdown <= 4'd0;
                    end else begin
                        r_countdown <= r_countdown - 4'd1;
                        if (r_blink_cnt == BL_W'(BLINK_HALF - 1)) begin
                            r_blink_cnt <= '0;
                            r_dont_walk <= ~r_dont_walk;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + BL_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_FAULT;
                end
            endcase
            // A fresh press wins over the grant clear so it is served at the next red.
            if (w_press) begin
                r_req <= 1'b1;
            end
        end
    end

    assign bus.walk        = r_walk;
    assign bus.dont_walk   = r_dont_walk;
    assign bus.flash       = r_flash;
    assign bus.countdown   = r_countdown;
    assign bus.req_pending = r_req;
    assign bus.fault       = r_fault;
endmodule

// File: doc/ped_walk_controller.md
# ped_walk_controller

Pedestrian-crossing stage that sits directly downstream of the three-state traffic light controller. It consumes the light's one-hot red/yellow/green outputs and a raw pedestrian push-button. It drives the walk / don't-walk signal head, including a flashing clearance interval with a countdown. A walk phase is granted only at the start of a red interval for which a request is pending. Illegal light codes force a sticky fault.

## Interface
Parameters:
- DEBOUNCE, 4: consecutive synchronized-high cycles required to accept a button press (≥1)
- WALK_CYCLES, 8: cycles of steady WALK (≥1)
- CLEAR_CYCLES, 6: cycles of flashing clearance (1..16)
- BLINK_HALF, 1: cycles per half-period of the clearance flash (≥1)

Ports:
- clk  in  1  single clock; light inputs are synchronous to it
- reset  in  1  synchronous, active-high reset
- red / yellow / green  in  1 each  light state from the upstream controller, expected one-hot
- ped_button  in  1  raw asynchronous push-button, active-high
- walk  out  1  steady WALK lamp
- dont_walk  out  1  DON'T WALK lamp (steady or flashing)
- flash  out  1  high during the clearance interval
- countdown  out  4  clearance cycles remaining; 0 outside clearance
- req_pending  out  1  latched pedestrian request awaiting service
- fault  out  1  sticky illegal-light-code flag

## Operation
- Button path: 2-flop synchronizer, then debounce counter. The counter increments while the synchronized level is 1 and clears when it is 0. The debounced level goes 1 when the count reaches DEBOUNCE. A rising edge of the debounced level sets req_pending. Holding the button produces exactly one request.
- red_d is a registered copy of red. red_rise = red & ~red_d.
- States:
  - IDLE: dont_walk=1, walk=0, flash=0, countdown=0.
  - WALK: walk=1, dont_walk=0. Lasts WALK_CYCLES cycles.
  - CLEAR: walk=0, flash=1. dont_walk starts at 1 and toggles every BLINK_HALF cycles. countdown runs CLEAR_CYCLES-1 down to 0, one step per cycle. Lasts CLEAR_CYCLES cycles.
  - FAULT: dont_walk=1, all other outputs 0.
- IDLE→WALK when red_rise & req_pending. req_pending clears on the same edge.
- WALK→CLEAR after WALK_CYCLES cycles. CLEAR→IDLE after CLEAR_CYCLES cycles.
- A request arriving while red is already high, or during WALK/CLEAR, stays latched and is served at the next red_rise. It does not extend or restart the current phase.
- Early abort: if red falls while in WALK or CLEAR, the next state is IDLE. A pending request is kept.
- Simultaneous red_rise and debounced button edge in IDLE: the new request does not grant this red. req_pending is set and stays set.
- Fault: any cycle in which {red,yellow,green} is not exactly one-hot forces FAULT on the next edge, from any state.
  - fault=1 and req_pending=0 while in FAULT; button input is ignored.
  - Only reset exits FAULT.
- countdown width: 4 bits. CLEAR_CYCLES above 16 is illegal and is not supported.

## Timing
- Reset values (cycle after reset is sampled high): state IDLE, walk=0, dont_walk=1, flash=0, countdown=0, req_pending=0, fault=0, red_d=0. Synchronizer and debounce registers are cleared.
- reset asserted mid-WALK/CLEAR/FAULT: outputs return to reset values on that edge.
- Button latency: button sampled high at edge N and held → req_pending=1 after edge N+DEBOUNCE+2.
- Grant latency: red rises (upstream register) at edge R with req_pending=1 → walk=1 after edge R+1.
  - walk stays high for exactly WALK_CYCLES cycles.
  - flash is then high for exactly CLEAR_CYCLES cycles.
  - dont_walk returns steady 1 after edge R+1+WALK_CYCLES+CLEAR_CYCLES.
- Fault latency: illegal code present at edge F → fault=1 after edge F+1.
- All outputs are registered, with no combinational input-to-output paths.

## Test plan
- Reset: hold reset 2 cycles with red=1 → dont_walk=1, walk=0, flash=0, countdown=0, fault=0, req_pending=0.
- Debounce: button glitches high 3 cycles with DEBOUNCE=4 → req_pending stays 0. Button held 10 cycles → req_pending=1 exactly 6 edges after the first high sample, and only one request is latched.
- Full cycle (defaults): request pending, green→yellow→red → walk=1 for 8 cycles.
  - Then flash=1 for 6 cycles, countdown 5,4,3,2,1,0, dont_walk toggling 1,0,1,0,1,0.
  - Then IDLE with req_pending=0.
- No request: red interval with req_pending=0 → walk never asserts. A press mid-red → walk at the next red only.
- Early abort: red drops after walk cycle 3 → IDLE next edge, countdown=0. A press during WALK leaves req_pending=1 afterwards.
- Fault: drive red=green=1 for one cycle during WALK → fault=1 and dont_walk=1 next edge, stays through later legal codes and presses. Reset clears it.
